// File: rtl/init_cfg_seq.sv
// Power-up configuration sequencer: streams N_WORDS words from a synchronous ROM over valid/ready.
// Optional feature macro: CFG_TIMEOUT_EN (send timeout -> ERR state, sticky o_cfg_err).
module init_cfg_seq #(
   parameter int N_WORDS     = 8,
   parameter int WORD_W      = 24,
   parameter int GAP_CYC     = 16,
   parameter int TIMEOUT_CYC = 1024,
   localparam int AW         = (N_WORDS > 1) ? $clog2(N_WORDS) : 1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_initial_flag,
   input  logic              i_rerun,
   output logic [AW-1:0]     o_rom_addr,
   input  logic [WORD_W-1:0] i_rom_data,
   output logic [WORD_W-1:0] o_cfg_word,
   output logic              o_cfg_valid,
   input  logic              i_cfg_ready,
   output logic              o_cfg_busy,
   output logic              o_cfg_done,
   output logic              o_cfg_err,
   output logic [8:0]        o_words_sent,
   output logic [2:0]        o_dbg_state
);

   // Handshake: a word transfers on the edge where o_cfg_valid && i_cfg_ready;
   // o_cfg_word is held constant while o_cfg_valid && !i_cfg_ready.
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH1 = 3'd1,
      FETCH2 = 3'd2,
      SEND   = 3'd3,
      GAP    = 3'd4,
      DONE   = 3'd5,
      ERR    = 3'd6
   } state_t;

   localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
   localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
   localparam logic [AW-1:0] IDX_LAST = AW'(N_WORDS - 1);

   state_t              r_state, w_state_nx;
   logic [AW-1:0]       r_idx, w_idx_nx;
   logic [AW-1:0]       r_rom_addr, w_addr_nx;
   logic [WORD_W-1:0]   r_cfg_word, w_word_nx;
   logic                r_cfg_valid, w_valid_nx;
   logic                r_cfg_busy, w_busy_nx;
   logic                r_cfg_done, w_done_nx;
   logic                r_cfg_err, w_err_nx;
   logic [8:0]          r_words_sent, w_ws_nx;
   logic [GW-1:0]       r_gap_cnt, w_gap_nx;
`ifdef CFG_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
   logic [TW-1:0]       r_to_cnt, w_to_nx;
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= IDLE;
         r_idx        <= '0;
         r_rom_addr   <= '0;
         r_cfg_word   <= '0;
         r_cfg_valid  <= 1'b0;
         r_cfg_busy   <= 1'b0;
         r_cfg_done   <= 1'b0;
         r_cfg_err    <= 1'b0;
         r_words_sent <= '0;
         r_gap_cnt    <= '0;
`ifdef CFG_TIMEOUT_EN
         r_to_cnt     <= '0;
`endif
      end else begin
         r_state      <= w_state_nx;
         r_idx        <= w_idx_nx;
         r_rom_addr   <= w_addr_nx;
         r_cfg_word   <= w_word_nx;
         r_cfg_valid  <= w_valid_nx;
         r_cfg_busy   <= w_busy_nx;
         r_cfg_done   <= w_done_nx;
         r_cfg_err    <= w_err_nx;
         r_words_sent <= w_ws_nx;
         r_gap_cnt    <= w_gap_nx;
`ifdef CFG_TIMEOUT_EN
         r_to_cnt     <= w_to_nx;
`endif
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_idx_nx   = r_idx;
      w_addr_nx  = r_rom_addr;
      w_word_nx  = r_cfg_word;
      w_valid_nx = r_cfg_valid;
      w_done_nx  = r_cfg_done;
      w_err_nx   = r_cfg_err;
      w_ws_nx    = r_words_sent;
      w_gap_nx   = r_gap_cnt;
`ifdef CFG_TIMEOUT_EN
      w_to_nx    = r_to_cnt;
`endif
      case (r_state)
         IDLE: begin
            if (i_initial_flag) begin
               w_state_nx = FETCH1;
               w_idx_nx   = '0;
               w_addr_nx  = '0;
            end
         end
         FETCH1: w_state_nx = FETCH2;
         FETCH2: begin
            w_word_nx  = i_rom_data;
            w_valid_nx = 1'b1;
            w_state_nx = SEND;
`ifdef CFG_TIMEOUT_EN
            w_to_nx    = '0;
`endif
         end
         SEND: begin
            if (i_cfg_ready) begin
               w_valid_nx = 1'b0;
               w_ws_nx    = r_words_sent + 9'd1;
               if (r_idx == IDX_LAST) begin
                  w_state_nx = DONE;
                  w_done_nx  = 1'b1;
               end else if (GAP_CYC > 0) begin
                  w_state_nx = GAP;
                  w_gap_nx   = '0;
               end else begin
                  w_state_nx = FETCH1;
                  w_idx_nx   = r_idx + AW'(1);
                  w_addr_nx  = r_idx + AW'(1);
               end
            end
`ifdef CFG_TIMEOUT_EN
            // A transfer on the last allowed cycle takes priority over the timeout.
            else if (r_to_cnt == TO_LAST) begin
               w_state_nx = ERR;
               w_err_nx   = 1'b1;
               w_valid_nx = 1'b0;
            end else begin
               w_to_nx = r_to_cnt + TW'(1);
            end
`endif
         end
         GAP: begin
            if (r_gap_cnt == GAP_LAST) begin
               w_state_nx = FETCH1;
               w_idx_nx   = r_idx + AW'(1);
               w_addr_nx  = r_idx + AW'(1);
            end else begin
               w_gap_nx = r_gap_cnt + GW'(1);
            end
         end
         DONE, ERR: begin
            if (i_rerun) begin
               w_state_nx = FETCH1;
               w_idx_nx   = '0;
               w_addr_nx  = '0;
               w_ws_nx    = '0;
               w_done_nx  = 1'b0;
               w_err_nx   = 1'b0;
            end
         end
         default: w_state_nx = IDLE;
      endcase
      // Dropping initial_flag aborts from anywhere, discarding any in-flight word.
      if (!i_initial_flag && r_state != IDLE) begin
         w_state_nx = IDLE;
         w_valid_nx = 1'b0;
         w_done_nx  = 1'b0;
         w_err_nx   = 1'b0;
         w_ws_nx    = '0;
         w_idx_nx   = '0;
         w_addr_nx  = '0;
      end
      w_busy_nx = (w_state_nx == FETCH1) || (w_state_nx == FETCH2) ||
                  (w_state_nx == SEND)   || (w_state_nx == GAP);
   end

   assign o_rom_addr   = r_rom_addr;
   assign o_cfg_word   = r_cfg_word;
   assign o_cfg_valid  = r_cfg_valid;
   assign o_cfg_busy   = r_cfg_busy;
   assign o_cfg_done   = r_cfg_done;
   assign o_cfg_err    = r_cfg_err;
   assign o_words_sent = r_words_sent;
   assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_init_cfg_seq.sv
// Bench for init_cfg_seq: random ready/abort stimulus, run-level reference model and word scoreboard.
module tb_init_cfg_seq;
   localparam int N   = 8;
   localparam int W   = 24;
   localparam int GAP = 16;
   localparam int TO  = 1024;

   // clock / reset
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst = 1'b1;
   logic          flag = 1'b0;
   logic          rerun = 1'b0;
   logic          ready = 1'b0;
   logic [2:0]    rom_addr;
   logic [W-1:0]  rom_data = '0;
   logic [W-1:0]  cfg_word;
   logic          cfg_valid, cfg_busy, cfg_done, cfg_err;
   logic [8:0]    words_sent;
   logic [2:0]    dbg_state;

   init_cfg_seq #(.N_WORDS(N), .WORD_W(W), .GAP_CYC(GAP), .TIMEOUT_CYC(TO)) dut (
      .i_clk(clk), .i_rst(rst), .i_initial_flag(flag), .i_rerun(rerun),
      .o_rom_addr(rom_addr), .i_rom_data(rom_data), .o_cfg_word(cfg_word),
      .o_cfg_valid(cfg_valid), .i_cfg_ready(ready), .o_cfg_busy(cfg_busy),
      .o_cfg_done(cfg_done), .o_cfg_err(cfg_err), .o_words_sent(words_sent),
      .o_dbg_state(dbg_state)
   );

   // synchronous ROM with one cycle of read latency
   logic [W-1:0] rom [N];
   always @(posedge clk) rom_data <= rom[rom_addr];

   int     tests = 0;
   int     fails = 0;
   longint cyc = 0;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // reference model: one run = the ROM contents in address order
   logic [W-1:0] exp_q[$];
   bit  m_idle = 1'b1;
   int  m_count = 0;
   bit  m_err = 1'b0;
   int  m_wait = 0;

   logic         s_rst = 1'b1, s_flag = 1'b0, s_rerun = 1'b0, s_valid = 1'b0, s_ready = 1'b0;
   logic [W-1:0] s_word = '0;

   task automatic start_run();
      m_count = 0;
      m_err   = 1'b0;
      m_wait  = 0;
      exp_q.delete();
      for (int i = 0; i < N; i++) exp_q.push_back(rom[i]);
   endtask

   // model step plus scoreboard pop, from inputs/outputs sampled before this edge
   always @(posedge clk) begin
      if (s_rst || !s_flag) begin
         m_idle = 1'b1; m_count = 0; m_err = 1'b0; m_wait = 0;
         exp_q.delete();
      end else if (m_idle) begin
         m_idle = 1'b0;
         start_run();
      end else if (s_rerun && (m_count == N || m_err)) begin
         start_run();
      end else if (s_valid && s_ready) begin
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_word: got %0h expected none (cycle %0d)", s_word, cyc);
         end else begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            if (s_word !== e) begin
               fails++;
               $display("FAIL word_%0d: got %0h expected %0h (cycle %0d)", m_count, s_word, e, cyc);
            end
         end
         m_count++;
         m_wait = 0;
      end else if (s_valid) begin
         m_wait++;
`ifdef CFG_TIMEOUT_EN
         if (m_wait == TO) begin
            m_err = 1'b1;
            m_wait = 0;
            exp_q.delete();
         end
`endif
      end
   end

   // monitor: status checks every cycle, away from the active edge
   bit           chk_en = 1'b0;
   bit           spacing_en = 1'b0;
   longint       last_rise = -1;
   logic         prev_valid = 1'b0;
   logic         p_hold = 1'b0;
   logic [W-1:0] p_word = '0;

   always @(negedge clk) begin
      if (chk_en) begin
         check("words_sent", words_sent, m_count);
         check("cfg_done", cfg_done, m_count == N);
         check("cfg_err", cfg_err, m_err);
         check("cfg_busy", cfg_busy, !m_idle && m_count < N && !m_err);
         if (p_hold && s_flag && !s_rst && !m_err) begin
            check("hold_valid", cfg_valid, 1'b1);
            check("hold_word", cfg_word, p_word);
         end
         if (spacing_en && cfg_valid && !prev_valid) begin
            if (last_rise >= 0) check("valid_spacing", cyc - last_rise, 19);
            last_rise = cyc;
         end
      end
      p_hold     = cfg_valid && !cfg_ready_s();
      p_word     = cfg_word;
      prev_valid = cfg_valid;
      s_rst = rst; s_flag = flag; s_rerun = rerun;
      s_valid = cfg_valid; s_ready = ready; s_word = cfg_word;
   end

   function automatic logic cfg_ready_s();
      return ready;
   endfunction

   // driver tasks
   bit rnd_mode = 1'b0;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         if (rnd_mode) ready = ($urandom_range(0, 3) != 0);
      end
   endtask

   task automatic pulse_rerun();
      rerun = 1'b1;
      tick(1);
      rerun = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int k = 0;
      while (!cfg_done && k < budget) begin tick(1); k++; end
      tests++;
      if (!cfg_done) begin
         fails++;
         $display("FAIL wait_done: got timeout expected cfg_done within %0d cycles", budget);
      end
   endtask

   task automatic wait_word(input int ws, input bit want_valid, input int budget);
      int k = 0;
      while (!(cfg_valid == want_valid && cfg_busy && words_sent == ws) && k < budget) begin
         tick(1); k++;
      end
      tests++;
      if (k >= budget) begin
         fails++;
         $display("FAIL wait_word_%0d: got timeout expected state within %0d cycles", ws, budget);
      end
   endtask

   task automatic reset_check(input string tag);
      check({tag, "_rom_addr"}, rom_addr, 0);
      check({tag, "_cfg_word"}, cfg_word, 0);
      check({tag, "_cfg_valid"}, cfg_valid, 0);
      check({tag, "_cfg_busy"}, cfg_busy, 0);
      check({tag, "_cfg_done"}, cfg_done, 0);
      check({tag, "_cfg_err"}, cfg_err, 0);
      check({tag, "_words_sent"}, words_sent, 0);
   endtask

   initial begin
      for (int i = 0; i < N; i++) rom[i] = W'($urandom);
      rst = 1'b1;
      tick(3);
      reset_check("reset");
      chk_en = 1'b1;
      rst = 1'b0;

      // in-order run with ready always high; valid rises 19 cycles apart
      flag = 1'b1;
      ready = 1'b1;
      spacing_en = 1'b1;
      wait_done(400);
      spacing_en = 1'b0;
      tick(2);
      check("queue_empty_run1", exp_q.size(), 0);

      // replay from DONE; stall word 3 for 50 cycles; rerun during SEND ignored
      pulse_rerun();
      rnd_mode = 1'b1;
      wait_word(2, 1'b1, 500);
      rnd_mode = 1'b0;
      ready = 1'b0;
      tick(25);
      pulse_rerun();
      tick(24);
      check("stall_ws", words_sent, 2);
      rnd_mode = 1'b1;
      wait_done(1000);
      rnd_mode = 1'b0;

      // abort in GAP after word 4, then restart from word 0
      pulse_rerun();
      ready = 1'b1;
      wait_word(4, 1'b0, 400);
      flag = 1'b0;
      tick(1);
      check("abort_ws", words_sent, 0);
      check("abort_busy", cfg_busy, 0);
      check("abort_valid", cfg_valid, 0);
      tick(2);
      flag = 1'b1;
      wait_done(400);
      tick(2);
      check("queue_empty_run3", exp_q.size(), 0);

      // ready never high on word 2
      pulse_rerun();
      ready = 1'b1;
      wait_word(1, 1'b1, 400);
      ready = 1'b0;
      tick(1100);
`ifdef CFG_TIMEOUT_EN
      check("timeout_err", cfg_err, 1);
      check("timeout_ws", words_sent, 1);
      check("timeout_valid", cfg_valid, 0);
      ready = 1'b1;
      pulse_rerun();
`else
      check("no_timeout_valid", cfg_valid, 1);
      check("no_timeout_err", cfg_err, 0);
      ready = 1'b1;
`endif
      wait_done(400);

      // reset mid-SEND
      pulse_rerun();
      rnd_mode = 1'b1;
      wait_word(3, 1'b1, 600);
      rnd_mode = 1'b0;
      rst = 1'b1;
      tick(1);
      reset_check("mid_rst");
      rst = 1'b0;
      ready = 1'b1;
      wait_done(400);

      // random aborts at random points, each followed by a complete run
      for (int r = 0; r < 4; r++) begin
         rnd_mode = 1'b1;
         if (cfg_done) pulse_rerun();
         tick($urandom_range(5, 150));
         flag = 1'b0;
         tick($urandom_range(1, 3));
         flag = 1'b1;
         wait_done(1000);
      end
      rnd_mode = 1'b0;
      tick(2);
      check("queue_empty_final", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "global timeout");
   end
endmodule
